dfs_sphere_ctrl: RTL

//  Parametrised depth-first sphere-decoder tree controller, successor to the fixed 4-level/8-ary exhaustive dfs.

---
 rtl/dfs_sphere_ctrl_pkg.sv | 26 ++
 rtl/dfs_sphere_ctrl_if.sv | 45 ++++
 rtl/dfs_sphere_ctrl_next_node.sv | 40 ++++
 rtl/dfs_sphere_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/dfs_sphere_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dfs_sphere_ctrl_pkg
// Shared definitions for the depth-first sphere-decoder tree controller:
// default parameter values, the controller state encoding and a helper that
// sizes the level field.
// No ports (package).
// -----------------------------------------------------------------------------
package dfs_sphere_ctrl_pkg;

   localparam int DEF_WIDTH    = 32;
   localparam int DEF_NLVL     = 4;
   localparam int DEF_SYM_BITS = 3;
   localparam int DEF_CNT_W    = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // A single-level tree still needs a one-bit level field.
   function automatic int lvl_width(input int nlvl);
      return (nlvl > 1) ? $clog2(nlvl) : 1;
   endfunction

endpackage

// File: rtl/dfs_sphere_ctrl_if.sv
// -----------------------------------------------------------------------------
// dfs_sphere_ctrl_if
// Bundles the search control, the metric feedback loop and the result/status
// signals of dfs_sphere_ctrl.
//   start, prune_en, init_radius, node_limit : search request (master -> slave)
//   node_cost                                : partial metric of node (s, lvl)
//   s, lvl                                   : node under evaluation
//   s_best, best_cost, found, timeout        : search result
//   node_count, busy, done                   : progress / completion
// Modports: master = requester + metric calculator, slave = controller.
// -----------------------------------------------------------------------------
interface dfs_sphere_ctrl_if #(
   parameter int WIDTH    = dfs_sphere_ctrl_pkg::DEF_WIDTH,
   parameter int NLVL     = dfs_sphere_ctrl_pkg::DEF_NLVL,
   parameter int SYM_BITS = dfs_sphere_ctrl_pkg::DEF_SYM_BITS,
   parameter int CNT_W    = dfs_sphere_ctrl_pkg::DEF_CNT_W
);
   localparam int LVL_W = dfs_sphere_ctrl_pkg::lvl_width(NLVL);

   logic                     start;
   logic                     prune_en;
   logic [WIDTH-1:0]         init_radius;
   logic [CNT_W-1:0]         node_limit;
   logic [WIDTH-1:0]         node_cost;
   logic [NLVL*SYM_BITS-1:0] s;
   logic [LVL_W-1:0]         lvl;
   logic [NLVL*SYM_BITS-1:0] s_best;
   logic [WIDTH-1:0]         best_cost;
   logic                     found;
   logic                     timeout;
   logic [CNT_W-1:0]         node_count;
   logic                     busy;
   logic                     done;

   modport master (
      output start, prune_en, init_radius, node_limit, node_cost,
      input  s, lvl, s_best, best_cost, found, timeout, node_count, busy, done
   );

   modport slave (
      input  start, prune_en, init_radius, node_limit, node_cost,
      output s, lvl, s_best, best_cost, found, timeout, node_count, busy, done
   );

endinterface

// File: rtl/dfs_sphere_ctrl_next_node.sv
// -----------------------------------------------------------------------------
// dfs_sphere_ctrl_next_node
// Combinational depth-first advance: from the current path and level, find the
// lowest level at or above lvl whose symbol can still be incremented, and step
// it. Levels below the returned level are left untouched (don't-care).
//   s         in  current path, level l at [l*SYM_BITS +: SYM_BITS]
//   lvl       in  current level
//   s_next    out advanced path
//   lvl_next  out level of the advanced node
//   exhausted out no sibling left anywhere above: the tree is finished
// -----------------------------------------------------------------------------
module dfs_sphere_ctrl_next_node #(
   parameter int NLVL     = dfs_sphere_ctrl_pkg::DEF_NLVL,
   parameter int SYM_BITS = dfs_sphere_ctrl_pkg::DEF_SYM_BITS,
   parameter int LVL_W    = dfs_sphere_ctrl_pkg::lvl_width(NLVL)
) (
   input  logic [NLVL*SYM_BITS-1:0] s,
   input  logic [LVL_W-1:0]         lvl,
   output logic [NLVL*SYM_BITS-1:0] s_next,
   output logic [LVL_W-1:0]         lvl_next,
   output logic                     exhausted
);

   // Scan from the root downwards so that the last hit, which wins, is the
   // lowest eligible level.
   always_comb begin
      s_next    = s;
      lvl_next  = lvl;
      exhausted = 1'b1;
      for (int l = NLVL - 1; l >= 0; l--) begin
         if (l >= int'(lvl) && !(&s[l*SYM_BITS +: SYM_BITS])) begin
            s_next = s;
            s_next[l*SYM_BITS +: SYM_BITS] = s[l*SYM_BITS +: SYM_BITS] + SYM_BITS'(1);
            lvl_next  = LVL_W'(l);
            exhausted = 1'b0;
         end
      end
   end

endmodule

// File: rtl/dfs_sphere_ctrl.sv
// -----------------------------------------------------------------------------
// dfs_sphere_ctrl
// Depth-first sphere-decoder tree controller. Walks the M-ary tree one node per
// cycle, presenting (s, lvl) to an external combinational metric calculator and
// using the returned node_cost in the same cycle. Prunes subtrees whose partial
// cost is not below the radius (or searches exhaustively), shrinks the radius on
// every better leaf, and can stop early on a node budget.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dfs_sphere_ctrl_if slave (request, metric loop, results, status)
// -----------------------------------------------------------------------------
module dfs_sphere_ctrl
   import dfs_sphere_ctrl_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int NLVL     = DEF_NLVL,
   parameter int SYM_BITS = DEF_SYM_BITS,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   dfs_sphere_ctrl_if.slave   bus
);

   localparam int               LVL_W    = lvl_width(NLVL);
   localparam int               SW       = NLVL * SYM_BITS;
   localparam logic [LVL_W-1:0] LVL_ROOT = LVL_W'(NLVL - 1);

   state_t            state_q, state_d;
   logic [SW-1:0]     s_q, s_d, best_s_q, best_s_d, adv_s;
   logic [LVL_W-1:0]  lvl_q, lvl_d, adv_lvl;
   logic [WIDTH-1:0]  best_cost_q, best_cost_d, radius_q, radius_d;
   logic              found_q, found_d, timeout_q, timeout_d;
   logic              prune_q, prune_d, adv_exh;
   logic [CNT_W-1:0]  count_q, count_d, limit_q, limit_d;
   logic              accept, budget_hit;
   logic [CNT_W-1:0]  count_inc;

   dfs_sphere_ctrl_next_node #(
      .NLVL     (NLVL),
      .SYM_BITS (SYM_BITS),
      .LVL_W    (LVL_W)
   ) u_next_node (
      .s         (s_q),
      .lvl       (lvl_q),
      .s_next    (adv_s),
      .lvl_next  (adv_lvl),
      .exhausted (adv_exh)
   );

   // Register bank: everything resets to the idle/empty-result values, so an
   // assertion mid-search simply abandons the walk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         s_q         <= '0;
         lvl_q       <= LVL_ROOT;
         best_s_q    <= '0;
         best_cost_q <= '1;
         radius_q    <= '1;
         found_q     <= 1'b0;
         timeout_q   <= 1'b0;
         count_q     <= '0;
         prune_q     <= 1'b0;
         limit_q     <= '0;
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         lvl_q       <= lvl_d;
         best_s_q    <= best_s_d;
         best_cost_q <= best_cost_d;
         radius_q    <= radius_d;
         found_q     <= found_d;
         timeout_q   <= timeout_d;
         count_q     <= count_d;
         prune_q     <= prune_d;
         limit_q     <= limit_d;
      end
   end

   // Next-state and datapath. In EVAL a node either descends (accepted, or
   // exhaustive mode above the leaves) or the walk advances to the next
   // sibling/ancestor sibling. The budget stop only fires while the tree still
   // has nodes left, so hitting it on the very last node is a normal finish.
   always_comb begin
      state_d     = state_q;
      s_d         = s_q;
      lvl_d       = lvl_q;
      best_s_d    = best_s_q;
      best_cost_d = best_cost_q;
      radius_d    = radius_q;
      found_d     = found_q;
      timeout_d   = timeout_q;
      count_d     = count_q;
      prune_d     = prune_q;
      limit_d     = limit_q;
      accept      = bus.node_cost < radius_q;
      count_inc   = count_q + CNT_W'(1);
      budget_hit  = (limit_q != '0) && (count_inc == limit_q);

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d     = ST_EVAL;
               radius_d    = bus.init_radius;
               s_d         = '0;
               lvl_d       = LVL_ROOT;
               best_s_d    = '0;
               best_cost_d = '1;
               found_d     = 1'b0;
               timeout_d   = 1'b0;
               count_d     = '0;
               prune_d     = bus.prune_en;
               limit_d     = bus.node_limit;
            end
         end

         ST_EVAL: begin
            count_d = count_inc;
            if (lvl_q != '0 && (accept || !prune_q)) begin
               lvl_d = lvl_q - LVL_W'(1);
               for (int l = 0; l < NLVL; l++) begin
                  if (l == int'(lvl_q) - 1) s_d[l*SYM_BITS +: SYM_BITS] = '0;
               end
               if (budget_hit) begin
                  state_d   = ST_DONE;
                  timeout_d = 1'b1;
               end
            end else begin
               if (lvl_q == '0 && accept) begin
                  best_s_d    = s_q;
                  best_cost_d = bus.node_cost;
                  radius_d    = bus.node_cost;
                  found_d     = 1'b1;
               end
               if (adv_exh) begin
                  state_d = ST_DONE;
               end else begin
                  s_d   = adv_s;
                  lvl_d = adv_lvl;
                  if (budget_hit) begin
                     state_d   = ST_DONE;
                     timeout_d = 1'b1;
                  end
               end
            end
         end

         ST_DONE: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.s          = s_q;
   assign bus.lvl        = lvl_q;
   assign bus.s_best     = best_s_q;
   assign bus.best_cost  = best_cost_q;
   assign bus.found      = found_q;
   assign bus.timeout    = timeout_q;
   assign bus.node_count = count_q;
   assign bus.busy       = (state_q == ST_EVAL);
   assign bus.done       = (state_q == ST_DONE);

endmodule
